// File: rtl/gf163_acc_reduce.sv
// gf163_acc_reduce
// Digit-serial accumulate-and-reduce stage for the GF(2^163) multiplier.
// Every accepted partial product is folded into the accumulator as
//   acc = reduce((acc << DIGIT) ^ pp)  mod  f(x) = x^163 + x^7 + x^6 + x^3 + 1
// and after NUM_PP products the reduced field element is offered on a
// valid/ready result port.
//
// Build option: define GF163_ACC_ABORT_EN to add an 'abort' input that
// drops an in-flight multiplication (or an unclaimed result) back to IDLE.

module gf163_acc_reduce #(
    parameter int M      = 163,  // field degree, accumulator/result width
    parameter int IN_W   = 170,  // partial-product width, at most M+7
    parameter int DIGIT  = 4,    // accumulator shift per fold
    parameter int NUM_PP = 41    // partial products per multiplication, 1..255
) (
    input  logic            clk,
    input  logic            rst_n,
`ifdef GF163_ACC_ABORT_EN
    input  logic            abort,
`endif
    input  logic            start,
    input  logic            pp_valid,
    output logic            pp_ready,
    input  logic [IN_W-1:0] pp_data,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [M-1:0]    res_data,
    output logic            busy
);

    // FSM encoding
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int CNT_W = 8;

    // Low part of f(x): x^7 + x^6 + x^3 + 1. Every overflow bit x^(M+k)
    // is congruent to x^k times this, and k <= 6 keeps the result below
    // degree 14, so one fold always lands fully inside the accumulator.
    localparam logic [M-1:0]     POLY_LOW = M'(8'hC9);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PP - 1);

    logic [1:0]       state_q, state_d;
    logic [M-1:0]     acc_q,   acc_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             res_valid_q;

    logic [IN_W-1:0]  fold_t;
    logic [M-1:0]     acc_red;
    logic             accept;
    logic             abort_req;

`ifdef GF163_ACC_ABORT_EN
    // Abort only has an effect once a multiplication is under way.
    assign abort_req = abort && (state_q != S_IDLE);
`else
    // Without the abort option, ACC is left only by completion or reset.
    assign abort_req = 1'b0;
`endif

    // pp_ready is a pure state decode: no combinational path from pp_valid.
    assign pp_ready = (state_q == S_ACC);
    assign accept   = pp_valid && pp_ready;

    // Shift-and-fold datapath: carry-free product step plus single reduction.
    always_comb begin
        fold_t  = ({{(IN_W - M){1'b0}}, acc_q} << DIGIT) ^ pp_data;
        acc_red = fold_t[M-1:0];
        for (int i = M; i < IN_W; i++) begin
            if (fold_t[i]) begin
                acc_red = acc_red ^ (POLY_LOW << (i - M));
            end
        end
    end

    // Next-state logic for the IDLE -> ACC -> DONE sequence.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch can be inferred.
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_ACC;
                end
            end

            S_ACC: begin
                if (accept) begin
                    acc_d = acc_red;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_d = S_DONE;
                    end
                end
            end

            S_DONE: begin
                // Result is held until taken; start alongside res_ready
                // restarts immediately without an IDLE bubble.
                if (res_ready) begin
                    if (start) begin
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = S_ACC;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides accept, res_ready and start in the same cycle.
        if (abort_req) begin
            acc_d   = '0;
            cnt_d   = '0;
            state_d = S_IDLE;
        end
    end

    // State, accumulator, counter and registered result-valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            res_valid_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values, independent of order.
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            res_valid_q <= (state_d == S_DONE);
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = acc_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_gf163_acc_reduce.sv
// tb_gf163_acc_reduce
// Directed bench for gf163_acc_reduce: reset, unit value, shift chain,
// both fold boundaries, backpressure with a stalled consumer, back-to-back
// restart and reset mid-accumulation. Build with GF163_ACC_ABORT_EN to
// include the abort scenario.

module tb_gf163_acc_reduce;

    localparam int M      = 163;
    localparam int IN_W   = 170;
    localparam int DIGIT  = 4;
    localparam int NUM_PP = 41;

    localparam logic [M-1:0] POLY_LOW = 163'hC9;

    logic            clk;
    logic            rst_n;
    logic            abort;
    logic            start;
    logic            pp_valid;
    logic            pp_ready;
    logic [IN_W-1:0] pp_data;
    logic            res_valid;
    logic            res_ready;
    logic [M-1:0]    res_data;
    logic            busy;

    int n_compared;
    int n_mismatched;

    logic [IN_W-1:0] pp_vec [NUM_PP];

    gf163_acc_reduce #(
        .M      (M),
        .IN_W   (IN_W),
        .DIGIT  (DIGIT),
        .NUM_PP (NUM_PP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef GF163_ACC_ABORT_EN
        .abort     (abort),
`endif
        .start     (start),
        .pp_valid  (pp_valid),
        .pp_ready  (pp_ready),
        .pp_data   (pp_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [M-1:0] got, input logic [M-1:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: multiply by x one bit at a time, reduce pp high bits by
    // repeated doubling of the low polynomial.
    function automatic logic [M-1:0] mulx(input logic [M-1:0] a);
        logic [M-1:0] r;
        r = a << 1;
        if (a[M-1]) r = r ^ POLY_LOW;
        return r;
    endfunction

    function automatic logic [M-1:0] ref_result();
        logic [M-1:0] acc;
        logic [M-1:0] term;
        acc = '0;
        for (int k = 0; k < NUM_PP; k++) begin
            for (int s = 0; s < DIGIT; s++) acc = mulx(acc);
            acc = acc ^ pp_vec[k][M-1:0];
            for (int i = M; i < IN_W; i++) begin
                if (pp_vec[k][i]) begin
                    term = POLY_LOW;
                    for (int j = 0; j < i - M; j++) term = mulx(term);
                    acc = acc ^ term;
                end
            end
        end
        return acc;
    endfunction

    function automatic logic [IN_W-1:0] rnd_pp();
        logic [191:0] w;
        w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return w[IN_W-1:0];
    endfunction

    task automatic set_single(input int idx, input logic [IN_W-1:0] v);
        for (int k = 0; k < NUM_PP; k++) pp_vec[k] = '0;
        pp_vec[idx] = v;
    endtask

    // Called at posedge+1; returns at posedge+1 with the FSM in ACC.
    task automatic start_mult();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Feeds pp_vec; n_edges counts edges including the start edge.
    task automatic feed(input string tag, input bit gaps, output int n_edges);
        int idx;
        int guard;
        idx     = 0;
        guard   = 0;
        n_edges = 1;
        while (idx < NUM_PP && guard < 2000) begin
            pp_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            pp_data  = pp_valid ? pp_vec[idx] : rnd_pp();
            if (pp_valid && idx == NUM_PP - 1)
                check({tag, "_valid_early"}, M'(res_valid), M'(0));
            @(posedge clk); #1;
            n_edges++;
            guard++;
            if (pp_valid) idx++;
        end
        pp_valid = 1'b0;
        pp_data  = rnd_pp();
        if (guard >= 2000) check({tag, "_timeout"}, M'(idx), M'(NUM_PP));
    endtask

    task automatic take_result(input string tag);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check({tag, "_taken_valid"}, M'(res_valid), M'(0));
        check({tag, "_taken_busy"},  M'(busy),      M'(0));
    endtask

    task automatic run_directed(input string tag, input logic [M-1:0] exp);
        int n;
        start_mult();
        feed(tag, 1'b0, n);
        check({tag, "_latency"}, M'(n), M'(NUM_PP + 1));
        check({tag, "_valid"},   M'(res_valid), M'(1));
        check({tag, "_data"},    res_data, exp);
        take_result(tag);
    endtask

    initial begin
        logic [M-1:0] exp_v;
        logic [M-1:0] gapfree_v;
        logic [IN_W-1:0] one;
        int n;

        n_compared   = 0;
        n_mismatched = 0;
        one          = IN_W'(1);
        rst_n        = 1'b0;
        abort        = 1'b0;
        start        = 1'b0;
        pp_valid     = 1'b0;
        pp_data      = '0;
        res_ready    = 1'b0;

        // Reset state
        #12;
        check("rst_pp_ready",  M'(pp_ready),  M'(0));
        check("rst_res_valid", M'(res_valid), M'(0));
        check("rst_busy",      M'(busy),      M'(0));
        check("rst_res_data",  res_data,      M'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Start moves to ACC next cycle
        start_mult();
        check("start_pp_ready", M'(pp_ready), M'(1));
        check("start_busy",     M'(busy),     M'(1));
        set_single(NUM_PP - 1, one);
        feed("unit", 1'b0, n);
        check("unit_latency", M'(n), M'(NUM_PP + 1));
        check("unit_valid",   M'(res_valid), M'(1));
        check("unit_data",    res_data, M'(1));
        take_result("unit");

        // Shift chain: x^160
        set_single(0, one);
        exp_v = '0;
        exp_v[160] = 1'b1;
        run_directed("shift", exp_v);

        // Fold boundaries
        set_single(NUM_PP - 1, one << 163);
        run_directed("fold163", M'(163'hC9));
        set_single(NUM_PP - 1, one << 169);
        run_directed("fold169", M'(163'h3240));

        // Random data, gap-free
        for (int k = 0; k < NUM_PP; k++) pp_vec[k] = rnd_pp();
        exp_v = ref_result();
        start_mult();
        feed("rnd", 1'b0, n);
        check("rnd_valid", M'(res_valid), M'(1));
        check("rnd_data",  res_data, exp_v);
        gapfree_v = res_data;
        take_result("rnd");

        // Same data with pp_valid bubbles, then stalled consumer
        start_mult();
        feed("bp", 1'b1, n);
        check("bp_valid",     M'(res_valid), M'(1));
        check("bp_same_data", res_data, gapfree_v);
        for (int c = 0; c < 5; c++) begin
            start = 1'b1;  // must be ignored in DONE without res_ready
            @(posedge clk); #1;
            check("stall_valid", M'(res_valid), M'(1));
            check("stall_data",  res_data, exp_v);
        end
        start = 1'b0;
        take_result("bp");

        // Back-to-back: res_ready and start together in DONE
        start_mult();
        feed("b2b_a", 1'b0, n);
        check("b2b_a_data", res_data, exp_v);
        res_ready = 1'b1;
        start     = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        start     = 1'b0;
        check("b2b_pp_ready", M'(pp_ready),  M'(1));
        check("b2b_valid",    M'(res_valid), M'(0));
        check("b2b_acc_clr",  res_data,      M'(0));
        set_single(NUM_PP - 1, one);
        feed("b2b_b", 1'b0, n);
        check("b2b_b_valid", M'(res_valid), M'(1));
        check("b2b_b_data",  res_data, M'(1));
        take_result("b2b_b");

        // Reset mid-ACC
        for (int k = 0; k < NUM_PP; k++) pp_vec[k] = rnd_pp();
        start_mult();
        pp_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            pp_data = pp_vec[k];
            @(posedge clk); #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_pp_ready",  M'(pp_ready),  M'(0));
        check("mid_rst_res_valid", M'(res_valid), M'(0));
        check("mid_rst_busy",      M'(busy),      M'(0));
        check("mid_rst_res_data",  res_data,      M'(0));
        @(posedge clk); #3;
        rst_n = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            check("post_rst_valid", M'(res_valid), M'(0));
        end
        pp_valid = 1'b0;

`ifdef GF163_ACC_ABORT_EN
        // Abort at cnt=20 with a concurrent valid product
        start_mult();
        pp_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            pp_data = pp_vec[k];
            @(posedge clk); #1;
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_pp_ready", M'(pp_ready),  M'(0));
        check("abort_busy",     M'(busy),      M'(0));
        check("abort_res_data", res_data,      M'(0));
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            check("abort_no_valid", M'(res_valid), M'(0));
        end
        pp_valid = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
